// File: rtl/eval_dispatch.sv
// Dispatches boards to the lowest idle evaluator lane and returns the lane results in
// submission order through a reorder buffer indexed by submission sequence.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH (64*4)
`endif

module eval_dispatch #(
  parameter int EVAL_WIDTH  = 24,
  parameter int BOARD_WIDTH = `BOARD_WIDTH,
  parameter int LANES       = 2,
  parameter int ROB_DEPTH   = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [BOARD_WIDTH-1:0]            board_in,
  input  logic                              wtm_in,
  input  logic                              board_in_valid,
  output logic                              board_in_ready,
  output logic [LANES*BOARD_WIDTH-1:0]      lane_board,
  output logic [LANES-1:0]                  lane_wtm,
  output logic [LANES-1:0]                  lane_board_valid,
  output logic [LANES-1:0]                  lane_clear_eval,
  input  logic [LANES-1:0]                  lane_eval_valid,
  input  logic [LANES*EVAL_WIDTH-1:0]       lane_eval,
  output logic                              result_valid,
  input  logic                              result_ready,
  output logic signed [EVAL_WIDTH-1:0]      result_eval,
  output logic [$clog2(ROB_DEPTH)-1:0]      result_tag,
  output logic [$clog2(LANES):0]            result_lane,
  output logic [$clog2(ROB_DEPTH):0]        outstanding
);
  localparam int TW = $clog2(ROB_DEPTH);
  localparam int LW = $clog2(LANES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_CLEAR} lane_st_e;

  lane_st_e                         r_st     [LANES];
  lane_st_e                         w_st_nxt [LANES];
  logic [LANES-1:0][BOARD_WIDTH-1:0] r_board;
  logic [LANES-1:0]                 r_wtm;
  logic [TW-1:0]                    r_lane_tag [LANES];
  logic signed [EVAL_WIDTH-1:0]     r_rob_eval [ROB_DEPTH];
  logic [LW-1:0]                    r_rob_lane [ROB_DEPTH];
  logic [ROB_DEPTH-1:0]             r_rob_valid;
  logic [TW-1:0]                    r_head, r_tail;
  logic [TW:0]                      r_outstanding;

  logic                             w_any_idle;
  logic [LW-1:0]                    w_sel;
  logic                             w_accept, w_pop;
  logic [LANES-1:0]                 w_done;

  // Descending scan so the lowest idle index wins.
  always_comb begin
    w_any_idle = 1'b0;
    w_sel      = '0;
    for (int i = LANES-1; i >= 0; i--) begin
      if (r_st[i] == S_IDLE) begin
        w_any_idle = 1'b1;
        w_sel      = LW'(i);
      end
    end
  end

  assign board_in_ready = w_any_idle && (r_outstanding < (TW+1)'(ROB_DEPTH));
  assign w_accept       = board_in_valid && board_in_ready;
  assign w_pop          = result_valid && result_ready;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_st_nxt[i]         = r_st[i];
      w_done[i]           = 1'b0;
      lane_board_valid[i] = (r_st[i] == S_BUSY);
      lane_clear_eval[i]  = (r_st[i] == S_CLEAR);
      case (r_st[i])
        S_IDLE:  if (w_accept && w_sel == LW'(i)) w_st_nxt[i] = S_BUSY;
        S_BUSY:  if (lane_eval_valid[i]) begin
                   w_st_nxt[i] = S_CLEAR;
                   w_done[i]   = 1'b1;
                 end
        S_CLEAR: w_st_nxt[i] = S_IDLE;
        default: w_st_nxt[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) r_st[i] <= S_IDLE;
    end else begin
      for (int i = 0; i < LANES; i++) r_st[i] <= w_st_nxt[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_board <= '0;
      r_wtm   <= '0;
      for (int i = 0; i < LANES; i++) r_lane_tag[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (w_accept && w_sel == LW'(i)) begin
          r_board[i]    <= board_in;
          r_wtm[i]      <= wtm_in;
          r_lane_tag[i] <= r_tail;
        end
      end
    end
  end

  // A completing entry is never valid yet, so it cannot collide with the popped head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rob_valid   <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_outstanding <= '0;
      for (int k = 0; k < ROB_DEPTH; k++) begin
        r_rob_eval[k] <= '0;
        r_rob_lane[k] <= '0;
      end
    end else begin
      if (w_accept) r_tail <= r_tail + 1'b1;
      if (w_pop) begin
        r_rob_valid[r_head] <= 1'b0;
        r_head              <= r_head + 1'b1;
      end
      for (int i = 0; i < LANES; i++) begin
        if (w_done[i]) begin
          r_rob_valid[r_lane_tag[i]] <= 1'b1;
          r_rob_eval[r_lane_tag[i]]  <= $signed(lane_eval[i*EVAL_WIDTH +: EVAL_WIDTH]);
          r_rob_lane[r_lane_tag[i]]  <= LW'(i);
        end
      end
      case ({w_accept, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign lane_board   = r_board;
  assign lane_wtm     = r_wtm;
  assign result_valid = r_rob_valid[r_head];
  assign result_eval  = r_rob_eval[r_head];
  assign result_lane  = r_rob_lane[r_head];
  assign result_tag   = r_head;
  assign outstanding  = r_outstanding;
endmodule
